// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the oversampled SPI slave receiver.
package spi_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  function automatic spi_mode_t mode_of(input int cpol, input int cpha);
    return spi_mode_t'({cpol[0], cpha[0]});
  endfunction

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic bit sample_on_rise(input int cpol, input int cpha);
    return (cpol[0] == cpha[0]);
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_slave_rx_if.sv
// Received-word stream: the receiver drives data/valid (master), the consumer drives ready (slave).
interface spi_slave_rx_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous FIFO, no bypass: a pushed word is visible one clk later; a push when full is refused
// unless a pop happens in the same cycle. Pointers carry one wrap bit for full/empty.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int AW    = PTR_W - 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = LVL_W'(wr_q - rd_q);
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  // A pop frees the head slot in the same cycle, so a full FIFO may accept a push alongside it.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d = wr_q + PTR_W'(do_push);
    rd_d = rd_q + PTR_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// Oversampled SPI slave receiver: words reach out_valid SYNC_STAGES+2 clk after the last sample edge;
// a full FIFO drops the word and sets sticky overrun. SPI_RX_FRAME_ERR_EN adds the frame_err pulse.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       spi_sck,
  input  logic                       spi_csn,
  input  logic                       spi_sdi,
  spi_slave_rx_if.master             out_if,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy,
  output logic                       overrun,
  input  logic                       overrun_clr
`ifdef SPI_RX_FRAME_ERR_EN
  ,
  output logic                       frame_err
`endif
);

  localparam int                     CNT_W       = cnt_width(WIDTH);
  localparam bit                     SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam logic [CNT_W-1:0]       LAST_BIT    = CNT_W'(WIDTH - 1);
  localparam logic                   SCK_IDLE    = (CPOL != 0);

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] csn_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   sck_prev_q;
  logic                   csn_prev_q;

  logic                   sck_s, csn_s, sdi_s;
  logic                   sck_rise, sck_fall, sample_edge;
  logic                   csn_fall;

  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_cur;
  logic [WIDTH-1:0]       shift_q, shift_d, shift_nxt;
  logic                   push_q, push_d;
  logic                   overrun_q, overrun_d;

  logic [WIDTH-1:0]       fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   drop;

  // Equal-depth chains keep csn/sdi aligned with sck after synchronisation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= {SYNC_STAGES{SCK_IDLE}};
      csn_sync_q <= '1;
      sdi_sync_q <= '0;
      sck_prev_q <= SCK_IDLE;
      csn_prev_q <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      csn_sync_q <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
      sck_prev_q <= sck_s;
      csn_prev_q <= csn_s;
    end
  end

  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign csn_s       = csn_sync_q[SYNC_STAGES-1];
  assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise    = sck_s & ~sck_prev_q;
  assign sck_fall    = ~sck_s & sck_prev_q;
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  assign csn_fall    = ~csn_s & csn_prev_q;
  assign busy        = ~csn_s;

  always_comb begin
    shift_nxt = shift_q;
    if (MSB_FIRST != 0) begin
      shift_nxt = {shift_q[WIDTH-2:0], sdi_s};
    end else begin
      shift_nxt = {sdi_s, shift_q[WIDTH-1:1]};
    end
  end

`ifdef SPI_RX_FRAME_ERR_EN
  logic ferr_q, ferr_d;
  logic csn_rise;

  assign csn_rise  = csn_s & ~csn_prev_q;
  assign frame_err = ferr_q;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    cnt_cur = csn_fall ? '0 : cnt_q;
`ifdef SPI_RX_FRAME_ERR_EN
    ferr_d  = 1'b0;
`endif
    if (csn_s) begin
      // Deselected: any partial word is abandoned by holding the counter at zero.
      cnt_d = '0;
`ifdef SPI_RX_FRAME_ERR_EN
      ferr_d = csn_rise && (cnt_q != '0);
`endif
    end else begin
      cnt_d = cnt_cur;
      if (sample_edge) begin
        shift_d = shift_nxt;
        if (cnt_cur == LAST_BIT) begin
          cnt_d  = '0;
          push_d = 1'b1;
        end else begin
          cnt_d = cnt_cur + CNT_W'(1);
        end
      end
    end
  end

  // shift_q is stable in the push cycle because sample edges are at least four clk apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
      ferr_q    <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      overrun_q <= overrun_d;
`ifdef SPI_RX_FRAME_ERR_EN
      ferr_q    <= ferr_d;
`endif
    end
  end

  assign pop  = out_if.out_valid & out_if.out_ready;
  assign drop = push_q & fifo_full & ~pop;

  // A drop in the same cycle as a clear request keeps the flag set.
  assign overrun_d = drop | (overrun_q & ~overrun_clr);
  assign overrun   = overrun_q;

  spi_rx_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_q),
    .push_data_i (shift_q),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (level)
  );

  assign out_if.out_data  = fifo_head;
  assign out_if.out_valid = ~fifo_empty;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: one receiver per SPI mode (mode 3 LSB-first), scoreboard of expected words.
module tb_spi_slave_rx;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sck, csn, sdi, rdy, clr;
  logic [3:0] vld, busy, ovr;
  logic [7:0] dat [4];
  logic [2:0] lvl [4];
`ifdef SPI_RX_FRAME_ERR_EN
  logic [3:0] ferr;
  int         ferr_cnt = 0;
  always @(negedge clk) if (ferr[0] === 1'b1) ferr_cnt <= ferr_cnt + 1;
`endif

  int         tests = 0;
  int         fails = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_rx_if #(.WIDTH(8)) bus ();
    assign bus.out_ready = rdy[g];
    assign vld[g]        = bus.out_valid;
    assign dat[g]        = bus.out_data;

    spi_slave_rx #(
      .WIDTH       (8),
      .DEPTH       (4),
      .CPOL        (g / 2),
      .CPHA        (g % 2),
      .MSB_FIRST   ((g == 3) ? 0 : 1),
      .SYNC_STAGES (SYNC)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .spi_sck     (sck[g]),
      .spi_csn     (csn[g]),
      .spi_sdi     (sdi[g]),
      .out_if      (bus),
      .level       (lvl[g]),
      .busy        (busy[g]),
      .overrun     (ovr[g]),
      .overrun_clr (clr[g])
`ifdef SPI_RX_FRAME_ERR_EN
      ,
      .frame_err   (ferr[g])
`endif
    );
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic cpol_of(input int g);
    return (g >= 2);
  endfunction

  function automatic logic cpha_of(input int g);
    return ((g % 2) == 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit at f_clk/8: CPHA=0 sets data before the leading edge, CPHA=1 changes it on the leading edge.
  task automatic send_bit(input int g, input logic b);
    if (!cpha_of(g)) begin
      sdi[g] = b;
      tick(4);
      sck[g] = ~cpol_of(g);
      tick(4);
      sck[g] = cpol_of(g);
    end else begin
      sck[g] = ~cpol_of(g);
      sdi[g] = b;
      tick(4);
      sck[g] = cpol_of(g);
      tick(4);
    end
  endtask

  task automatic send_word(input int g, input logic [7:0] w, input int nbits, input bit expect_it);
    if (expect_it) sb.push_back(w);
    for (int i = 0; i < nbits; i++) send_bit(g, (g == 3) ? w[i] : w[7-i]);
  endtask

  task automatic csn_lo(input int g);
    csn[g] = 1'b0;
    tick(4);
  endtask

  task automatic csn_hi(input int g);
    tick(4);
    csn[g] = 1'b1;
    tick(8);
  endtask

  task automatic pop_check(input int g, input string tag, input logic hold);
    logic [7:0] exp;
    for (int i = 0; i < 300 && vld[g] !== 1'b1; i++) tick(1);
    chk({tag, "_valid"}, 32'(vld[g]), 1);
    if (vld[g] === 1'b1) begin
      exp = 'x;
      if (sb.size() != 0) exp = sb.pop_front();
      chk(tag, 32'(dat[g]), 32'(exp));
      rdy[g] = 1'b1;
      tick(1);
      rdy[g] = hold;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] w;
`ifdef SPI_RX_FRAME_ERR_EN
    int         f0;
`endif
    rst_n = 1'b0;
    sck   = 4'b1100;
    csn   = 4'hF;
    sdi   = 4'h0;
    rdy   = 4'h0;
    clr   = 4'h0;
    tick(3);
    for (int g = 0; g < 4; g++) begin
      chk("rst_valid", 32'(vld[g]), 0);
      chk("rst_level", 32'(lvl[g]), 0);
      chk("rst_busy", 32'(busy[g]), 0);
      chk("rst_overrun", 32'(ovr[g]), 0);
    end
    chk("rst_data", 32'(dat[0]), 0);
    rst_n = 1'b1;
    tick(4);
    chk("idle_valid", 32'(vld[0]), 0);

    // Mode 0 latency: count clk from the 8th rising sck at the pin to out_valid.
    csn_lo(0);
    chk("busy_in_frame", 32'(busy[0]), 1);
    w = 8'hA5;
    sb.push_back(w);
    for (int i = 0; i < 7; i++) send_bit(0, w[7-i]);
    sdi[0] = w[0];
    tick(4);
    sck[0] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      if (vld[0] === 1'b1 && lat == 0) lat = i;
    end
    chk("latency", 32'(lat), SYNC + 2);
    sck[0] = 1'b0;
    csn_hi(0);
    chk("busy_after_frame", 32'(busy[0]), 0);
    chk("mode0_level", 32'(lvl[0]), 1);
    pop_check(0, "mode0_a5", 1'b0);
    chk("mode0_level_after_pop", 32'(lvl[0]), 0);

    // Modes 1..3 (mode 3 LSB-first) each receive 0x3C and nothing else.
    for (int g = 1; g < 4; g++) begin
      csn_lo(g);
      send_word(g, 8'h3C, 8, 1'b1);
      csn_hi(g);
      pop_check(g, "mode_3c", 1'b0);
      tick(20);
      chk("mode_no_extra_valid", 32'(vld[g]), 0);
      chk("mode_no_extra_level", 32'(lvl[g]), 0);
    end

    // Back-to-back words in one frame with the consumer always ready.
    rdy[0] = 1'b1;
    csn_lo(0);
    fork
      for (int i = 1; i <= 3; i++) send_word(0, 8'(i), 8, 1'b1);
      for (int i = 0; i < 3; i++) pop_check(0, "b2b", 1'b1);
    join
    csn_hi(0);
    rdy[0] = 1'b0;
    chk("b2b_overrun", 32'(ovr[0]), 0);
    chk("b2b_level", 32'(lvl[0]), 0);

    // Five words into a four-deep FIFO: the fifth is dropped.
    csn_lo(0);
    for (int i = 0; i < 5; i++) send_word(0, 8'(16 + i), 8, i < 4);
    csn_hi(0);
    chk("ovf_level", 32'(lvl[0]), 4);
    chk("ovf_overrun", 32'(ovr[0]), 1);
    chk("ovf_head", 32'(dat[0]), 32'h10);
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    chk("ovf_clear", 32'(ovr[0]), 0);
    for (int i = 0; i < 4; i++) pop_check(0, "ovf_drain", 1'b0);
    chk("ovf_drain_level", 32'(lvl[0]), 0);

    // Frame aborted after 5 bits, then a complete word.
`ifdef SPI_RX_FRAME_ERR_EN
    f0 = ferr_cnt;
`endif
    csn_lo(0);
    send_word(0, 8'hFF, 5, 1'b0);
    csn_hi(0);
    csn_lo(0);
    send_word(0, 8'h81, 8, 1'b1);
    csn_hi(0);
    pop_check(0, "abort_81", 1'b0);
    tick(10);
    chk("abort_only_one", 32'(lvl[0]), 0);
`ifdef SPI_RX_FRAME_ERR_EN
    chk("abort_frame_err", 32'(ferr_cnt - f0), 1);
`endif

    // Reset mid-word with two words queued.
    csn_lo(0);
    send_word(0, 8'h11, 8, 1'b0);
    send_word(0, 8'h22, 8, 1'b0);
    send_word(0, 8'h33, 3, 1'b0);
    tick(4);
    chk("pre_reset_level", 32'(lvl[0]), 2);
    rst_n = 1'b0;
    #1;
    chk("reset_level", 32'(lvl[0]), 0);
    chk("reset_valid", 32'(vld[0]), 0);
    chk("reset_busy", 32'(busy[0]), 0);
    csn[0] = 1'b1;
    sck[0] = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    csn_lo(0);
    send_word(0, 8'h5A, 8, 1'b1);
    csn_hi(0);
    pop_check(0, "post_reset_5a", 1'b0);
    chk("final_overrun", 32'(ovr[0]), 0);
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
